// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: reserved encodings, reset PC default, fetch-state
// enum and the queue entry layout used by the fetch stage.
package rv32_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// In-order instruction queue of {instr, pc}. Flush beats push and pop; a push
// into a full queue is accepted only together with a pop.
module ifetch_queue
  import rv32_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  localparam int         PW       = $clog2(DEPTH),
  localparam int         CW       = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wr_entry,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  fetch_entry_t  mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify push/pop against flush and occupancy
  always_comb begin
    do_push_s = push & ~flush & ((count_r != CNT_FULL) | pop);
    do_pop_s  = pop & ~flush & (count_r != {CW{1'b0}});
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{instr: NOP_INSTR, pc: RESET_PC};
      end
    end else if (flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wr_entry;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/ifetch_unit.sv
// RV32I fetch stage: PC and credit accounting, in-order response capture and
// branch redirect with discard of stale in-flight responses.
module ifetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] C_ZERO  = CW'(1'b0);
  localparam logic [CW-1:0] C_ONE   = CW'(1'b1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [31:0] PC_STEP = 32'd4;

  fetch_state_e  state_r, state_s;
  logic [31:0]   fetch_pc_r, rsp_pc_r;
  logic [CW-1:0] outstanding_r, drop_r, out_after_s, count_s;
  logic          req_fire_s, consume_s, redirect_s, rsp_take_s, drain_rsp_s, credit_s;
  fetch_entry_t  head_s, wr_entry_s;

  // Event decode; a request accepted in the redirect cycle counts as stale
  always_comb begin
    credit_s    = ({1'b0, outstanding_r} + {1'b0, count_s}) < {1'b0, C_DEPTH};
    req_fire_s  = imem_req_valid & imem_req_ready;
    consume_s   = instr_valid & instr_ready;
    redirect_s  = consume_s & br_taken & (state_r == FETCH);
    rsp_take_s  = imem_rsp_valid & (state_r == FETCH) & (outstanding_r != C_ZERO);
    drain_rsp_s = imem_rsp_valid & (state_r == DRAIN) & (drop_r != C_ZERO);
    wr_entry_s  = '{instr: imem_rsp_data, pc: rsp_pc_r};
    case ({req_fire_s, rsp_take_s})
      2'b10:   out_after_s = outstanding_r + C_ONE;
      2'b01:   out_after_s = outstanding_r - C_ONE;
      default: out_after_s = outstanding_r;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      BOOT:  state_s = FETCH;
      FETCH: begin
        if (redirect_s && (out_after_s != C_ZERO)) begin
          state_s = DRAIN;
        end else begin
          state_s = FETCH;
        end
      end
      DRAIN: begin
        if (drain_rsp_s && (drop_r == C_ONE)) begin
          state_s = FETCH;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = BOOT;
    endcase
  end

  // Outputs; instr is forced to NOP whenever the head is empty
  always_comb begin
    imem_req_valid = (state_r == FETCH) & credit_s;
    imem_req_addr  = fetch_pc_r;
    instr_valid    = (count_s != C_ZERO);
    instr_pc       = head_s.pc;
    if (instr_valid) begin
      instr = head_s.instr;
    end else begin
      instr = NOP_INSTR;
    end
  end

  // PC counters and in-flight accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= C_ZERO;
      drop_r        <= C_ZERO;
    end else if (redirect_s) begin
      fetch_pc_r    <= word_align(br_target);
      rsp_pc_r      <= word_align(br_target);
      outstanding_r <= C_ZERO;
      drop_r        <= out_after_s;
    end else begin
      if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end
      if (rsp_take_s) begin
        rsp_pc_r <= rsp_pc_r + PC_STEP;
      end
      outstanding_r <= out_after_s;
      if (drain_rsp_s) begin
        drop_r <= drop_r - C_ONE;
      end
    end
  end

  ifetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (rsp_take_s & ~redirect_s),
    .pop      (consume_s),
    .flush    (redirect_s),
    .wr_entry (wr_entry_s),
    .head     (head_s),
    .count    (count_s)
  );

endmodule
